// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: slave state encoding and phase framing constants.
// Used by both the SCCB master and the loop-back slave.
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID,
        ST_SUB,
        ST_WDAT,
        ST_RDAT,
        ST_IGNORE
    } sccb_slv_st_e;

    localparam int   SCCB_BIT_PER_PHASE = 9;
    localparam logic SCCB_WR_BIT        = 1'b0;
    localparam logic SCCB_RD_BIT        = 1'b1;

endpackage

// File: rtl/sccb_slave_regfile_if.sv
// SCCB pad signals plus the register-write strobe port of the slave.
interface sccb_slave_regfile_if;

    logic       sio_c_i;
    logic       sio_d_i;
    logic       sio_d_o;
    logic       sio_d_oe_o;
    logic       wr_vld_o;
    logic [7:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic       busy_o;

    modport master (
        output sio_c_i, sio_d_i,
        input  sio_d_o, sio_d_oe_o, wr_vld_o, wr_addr_o, wr_data_o, busy_o
    );

    modport slave (
        input  sio_c_i, sio_d_i,
        output sio_d_o, sio_d_oe_o, wr_vld_o, wr_addr_o, wr_data_o, busy_o
    );

endinterface

// File: rtl/sccb_slave_regfile_line_sync.sv
// Synchronizes sio_c/sio_d into sys_clk and derives clock edge and
// START/STOP pulses. Chains reset to 1 so an idle (high) bus produces
// no spurious events when reset is released.
module sccb_line_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic sio_c,
    input  logic sio_d,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STG-1:0] c_sync;
    logic [SYNC_STG-1:0] d_sync;
    logic                c_q;
    logic                d_q;
    logic                scl;

    // Synchronizer chains followed by one extra stage for edge detection
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync <= '1;
            d_sync <= '1;
            c_q    <= 1'b1;
            d_q    <= 1'b1;
        end else begin
            c_sync <= {c_sync[SYNC_STG-2:0], sio_c};
            d_sync <= {d_sync[SYNC_STG-2:0], sio_d};
            c_q    <= c_sync[SYNC_STG-1];
            d_q    <= d_sync[SYNC_STG-1];
        end
    end

    assign scl      = c_sync[SYNC_STG-1];
    assign sda      = d_sync[SYNC_STG-1];
    assign scl_rise = scl & ~c_q;
    assign scl_fall = ~scl & c_q;
    assign start    = scl & c_q & d_q & ~sda;
    assign stop     = scl & c_q & ~d_q & sda;

endmodule

// File: rtl/sccb_slave_regfile.sv
// SCCB responder with an internal 8-bit register file for loop-back builds.
// Handles 3-phase write, 2-phase write and 2-phase read; every committed
// write is published on wr_vld_o/wr_addr_o/wr_data_o.
// Optional feature macro: SCCB_SLV_ACK_EN (drive an I2C-style ACK on the
// 9th bit of matched ID, SUB and WDAT phases).
module sccb_slave_regfile #(
    parameter logic [6:0] SLV_ID   = 7'h21,
    parameter int         REG_NUM  = 256,
    parameter int         SYNC_STG = 2
) (
    input logic                  sys_clk,
    input logic                  rst_n,
    sccb_slave_regfile_if.slave  bus
);

    import sccb_pkg::*;

    localparam logic [3:0] LAST_BIT = 4'(SCCB_BIT_PER_PHASE - 1);

    sccb_slv_st_e state;
    sccb_slv_st_e state_nxt;

    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;

    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] sub_addr;
    logic [7:0] regs [256];

    logic       sda_out;
    logic       sda_oe;
    logic       wr_vld;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    logic       active;
    logic       phase_done;
    logic       id_match;
    logic       sub_mapped;
    logic [7:0] rd_byte;

    sccb_line_sync #(.SYNC_STG(SYNC_STG)) u_sync (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .sio_c    (bus.sio_c_i),
        .sio_d    (bus.sio_d_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign active     = (state == ST_ID) || (state == ST_SUB) ||
                        (state == ST_WDAT) || (state == ST_RDAT);
    assign phase_done = scl_rise && active && (bit_cnt == LAST_BIT);
    assign id_match   = (shreg[7:1] == SLV_ID);
    assign sub_mapped = (32'(sub_addr) < REG_NUM);
    assign rd_byte    = sub_mapped ? regs[sub_addr] : 8'h00;

    // State register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: START/STOP override everything, otherwise advance per phase
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_ID;
        end else if (stop) begin
            state_nxt = ST_IDLE;
        end else if (phase_done) begin
            case (state)
                ST_ID:   state_nxt = !id_match ? ST_IGNORE :
                                     (shreg[0] == SCCB_RD_BIT) ? ST_RDAT : ST_SUB;
                ST_SUB:  state_nxt = ST_WDAT;
                ST_WDAT: state_nxt = ST_IGNORE;
                ST_RDAT: state_nxt = ST_IGNORE;
                default: state_nxt = state;
            endcase
        end
    end

    // Bit counter, shift register, sub-address and busy flag
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= 4'd0;
            shreg    <= 8'h00;
            sub_addr <= 8'h00;
            busy     <= 1'b0;
        end else if (start || stop) begin
            bit_cnt <= 4'd0;
            shreg   <= 8'h00;
            busy    <= start;
        end else begin
            if (scl_rise && active) begin
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= 4'd0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {shreg[6:0], sda};
                end
            end
            if (phase_done && state == ST_SUB) sub_addr <= shreg;
        end
    end

    // Write strobe: one-cycle pulse after the 9th bit of WDAT, even if unmapped
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld  <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
        end else begin
            wr_vld <= 1'b0;
            if (!start && !stop && phase_done && state == ST_WDAT) begin
                wr_vld  <= 1'b1;
                wr_addr <= sub_addr;
                wr_data <= shreg;
            end
        end
    end

    // Register file: updated together with the strobe, mapped addresses only
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
        end else if (!start && !stop && phase_done && state == ST_WDAT && sub_mapped) begin
            regs[sub_addr] <= shreg;
        end
    end

    // Bus drive: changes only after a synchronized sio_c falling edge
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe  <= 1'b0;
            sda_out <= 1'b0;
        end else if (start || stop) begin
            sda_oe  <= 1'b0;
            sda_out <= 1'b0;
        end else if (scl_fall) begin
            sda_oe  <= 1'b0;
            sda_out <= 1'b0;
            if (state == ST_RDAT && bit_cnt != LAST_BIT) begin
                sda_oe  <= 1'b1;
                sda_out <= rd_byte[~bit_cnt[2:0]];
            end
`ifdef SCCB_SLV_ACK_EN
            else if (bit_cnt == LAST_BIT &&
                     ((state == ST_ID && id_match) || state == ST_SUB || state == ST_WDAT)) begin
                sda_oe  <= 1'b1;
                sda_out <= 1'b0;
            end
`else
            else begin
                sda_oe  <= 1'b0;
                sda_out <= 1'b0;
            end
`endif
        end
    end

    assign bus.sio_d_o    = sda_out;
    assign bus.sio_d_oe_o = sda_oe;
    assign bus.wr_vld_o   = wr_vld;
    assign bus.wr_addr_o  = wr_addr;
    assign bus.wr_data_o  = wr_data;
    assign bus.busy_o     = busy;

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Self-checking bench for sccb_slave_regfile: directed vector table,
// hand-written abort/reset sequences and randomized transactions against a
// transaction-level register model.
module tb_sccb_slave_regfile;

    localparam int SYNC_STG = 2;
    localparam int REG_NUM  = 128;
    localparam int Q        = 4;
    localparam int K_W3     = 0;
    localparam int K_W2     = 1;
    localparam int K_R      = 2;
`ifdef SCCB_SLV_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic sys_clk  = 1'b0;
    logic rst_n    = 1'b0;
    logic master_c = 1'b1;
    logic master_d = 1'b1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } commit_t;
    commit_t commit_q[$];

    typedef struct {
        int         kind;
        logic [7:0] id;
        logic [7:0] sub;
        logic [7:0] data;
        logic       exp_vld;
        logic [7:0] exp_rd;
    } vec_t;
    vec_t vecs[15];

    logic [7:0] m_regs [256];
    logic [7:0] m_sub;

    always #5 sys_clk = ~sys_clk;

    sccb_slave_regfile_if sif();

    assign sif.sio_c_i = master_c;
    assign sif.sio_d_i = sif.sio_d_oe_o ? sif.sio_d_o : master_d;

    sccb_slave_regfile #(
        .SLV_ID   (7'h21),
        .REG_NUM  (REG_NUM),
        .SYNC_STG (SYNC_STG)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (sif)
    );

    // Collect every committed write strobe, one entry per high cycle
    always @(negedge sys_clk) begin
        if (rst_n && sif.wr_vld_o) commit_q.push_back('{sif.wr_addr_o, sif.wr_data_o});
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge sys_clk);
    endtask

    task automatic send_bit(input logic b, output logic s, output logic drv);
        master_d = b;
        wait_q();
        master_c = 1'b1;
        wait_q();
        s   = sif.sio_d_i;
        drv = sif.sio_d_oe_o;
        wait_q();
        master_c = 1'b0;
        wait_q();
    endtask

    task automatic sccb_start();
        master_d = 1'b1;
        wait_q();
        master_c = 1'b1;
        wait_q();
        master_d = 1'b0;
        wait_q();
        master_c = 1'b0;
        wait_q();
    endtask

    task automatic sccb_stop();
        master_d = 1'b0;
        wait_q();
        master_c = 1'b1;
        wait_q();
        master_d = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic s, drv, any_drv;
        any_drv = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], s, drv);
            any_drv |= drv;
        end
        send_bit(1'b1, s, drv);
        check_output({tag, " data-bit drive"}, 32'(any_drv), 32'd0);
        check_output({tag, " 9th bit {oe,low}"}, 32'({drv, ~s}), exp_ack ? 32'd3 : 32'd0);
    endtask

    task automatic read_byte(output logic [7:0] b, output logic all_drv, output logic na_drv);
        logic s, drv;
        all_drv = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s, drv);
            b[i] = s;
            all_drv &= drv;
        end
        send_bit(1'b1, s, na_drv);
    endtask

    task automatic apply_stimulus(input int kind, input logic [7:0] id, input logic [7:0] sub,
                                  input logic [7:0] data, input string tag, output logic [7:0] rd);
        logic matched, all_drv, na_drv;
        matched = (id[7:1] == 7'h21);
        rd = 8'h00;
        sccb_start();
        check_output({tag, " busy after START"}, 32'(sif.busy_o), 32'd1);
        write_byte(id, ACK_EN && matched, {tag, " id"});
        if (kind == K_R) begin
            read_byte(rd, all_drv, na_drv);
            check_output({tag, " read bits driven"}, 32'(all_drv), 32'd1);
            check_output({tag, " read 9th bit oe"}, 32'(na_drv), 32'd0);
        end else begin
            write_byte(sub, ACK_EN && matched, {tag, " sub"});
            if (kind == K_W3) write_byte(data, ACK_EN && matched, {tag, " wdat"});
        end
        sccb_stop();
        check_output({tag, " busy after STOP"}, 32'(sif.busy_o), 32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
        m_sub = 8'h00;
    endtask

    // Transaction-level reference: what a full transmission does to the slave
    task automatic model_txn(input int kind, input logic [7:0] id, input logic [7:0] sub,
                             input logic [7:0] data, output logic exp_vld, output logic [7:0] exp_rd);
        exp_vld = 1'b0;
        exp_rd  = 8'h00;
        if (kind == K_R && id == 8'h43) begin
            exp_rd = (int'(m_sub) < REG_NUM) ? m_regs[m_sub] : 8'h00;
        end else if (kind != K_R && id == 8'h42) begin
            m_sub = sub;
            if (kind == K_W3) begin
                exp_vld = 1'b1;
                if (int'(sub) < REG_NUM) m_regs[sub] = data;
            end
        end
    endtask

    task automatic check_commit(input logic exp_vld, input logic [7:0] a, input logic [7:0] d,
                                input string tag);
        commit_t c;
        check_output({tag, " commit count"}, 32'(commit_q.size()), 32'(exp_vld));
        if (exp_vld && commit_q.size() > 0) begin
            c = commit_q.pop_front();
            check_output({tag, " commit addr"}, 32'(c.addr), 32'(a));
            check_output({tag, " commit data"}, 32'(c.data), 32'(d));
        end
        commit_q.delete();
    endtask

    initial begin
        logic [7:0] rd, exp_rd, bad_ids [4];
        logic       exp_vld, s, drv;
        int         kind;
        logic [7:0] id, sub, data;

        bad_ids = '{8'h60, 8'h40, 8'h44, 8'hC2};

        vecs[0]  = '{K_W3, 8'h42, 8'h1A, 8'h5C, 1'b1, 8'h00};
        vecs[1]  = '{K_W2, 8'h42, 8'h1A, 8'h00, 1'b0, 8'h00};
        vecs[2]  = '{K_R,  8'h43, 8'h00, 8'h00, 1'b0, 8'h5C};
        vecs[3]  = '{K_W3, 8'h60, 8'h1A, 8'h77, 1'b0, 8'h00};
        vecs[4]  = '{K_W2, 8'h42, 8'h1A, 8'h00, 1'b0, 8'h00};
        vecs[5]  = '{K_R,  8'h43, 8'h00, 8'h00, 1'b0, 8'h5C};
        vecs[6]  = '{K_W3, 8'h42, 8'h7F, 8'h11, 1'b1, 8'h00};
        vecs[7]  = '{K_R,  8'h43, 8'h00, 8'h00, 1'b0, 8'h11};
        vecs[8]  = '{K_W3, 8'h42, 8'h80, 8'h33, 1'b1, 8'h00};
        vecs[9]  = '{K_R,  8'h43, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[10] = '{K_W2, 8'h42, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[11] = '{K_R,  8'h43, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[12] = '{K_W3, 8'h44, 8'h1A, 8'h99, 1'b0, 8'h00};
        vecs[13] = '{K_W2, 8'h42, 8'h1A, 8'h00, 1'b0, 8'h00};
        vecs[14] = '{K_R,  8'h43, 8'h00, 8'h00, 1'b0, 8'h5C};

        model_reset();

        // Reset state
        repeat (4) @(negedge sys_clk);
        check_output("outputs in reset",
                     32'({sif.sio_d_o, sif.sio_d_oe_o, sif.wr_vld_o, sif.wr_addr_o, sif.wr_data_o, sif.busy_o}),
                     32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        check_output("outputs after reset",
                     32'({sif.sio_d_o, sif.sio_d_oe_o, sif.wr_vld_o, sif.wr_addr_o, sif.wr_data_o, sif.busy_o}),
                     32'd0);
        commit_q.delete();

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].kind, vecs[i].id, vecs[i].sub, vecs[i].data,
                           $sformatf("vec%0d", i), rd);
            model_txn(vecs[i].kind, vecs[i].id, vecs[i].sub, vecs[i].data, exp_vld, exp_rd);
            check_commit(vecs[i].exp_vld, vecs[i].sub, vecs[i].data, $sformatf("vec%0d", i));
            if (vecs[i].kind == K_R) check_output($sformatf("vec%0d read data", i), 32'(rd), 32'(vecs[i].exp_rd));
        end

        // STOP after 4 bits of WDAT: SUB is latched, nothing commits
        sccb_start();
        write_byte(8'h42, ACK_EN, "abort1 id");
        write_byte(8'h10, ACK_EN, "abort1 sub");
        for (int i = 0; i < 4; i++) send_bit(1'b1, s, drv);
        sccb_stop();
        m_sub = 8'h10;
        check_commit(1'b0, 8'h00, 8'h00, "abort1");
        check_output("abort1 busy", 32'(sif.busy_o), 32'd0);

        // Repeated START in the middle of SUB, then a full write
        sccb_start();
        write_byte(8'h42, ACK_EN, "abort2 id");
        send_bit(1'b0, s, drv);
        send_bit(1'b1, s, drv);
        sccb_start();
        check_commit(1'b0, 8'h00, 8'h00, "abort2 restart");
        write_byte(8'h42, ACK_EN, "abort2 re-id");
        write_byte(8'h03, ACK_EN, "abort2 sub");
        write_byte(8'hA5, ACK_EN, "abort2 wdat");
        sccb_stop();
        model_txn(K_W3, 8'h42, 8'h03, 8'hA5, exp_vld, exp_rd);
        check_commit(1'b1, 8'h03, 8'hA5, "abort2");
        apply_stimulus(K_R, 8'h43, 8'h00, 8'h00, "abort2 rd", rd);
        model_txn(K_R, 8'h43, 8'h00, 8'h00, exp_vld, exp_rd);
        check_output("abort2 read data", 32'(rd), 32'(exp_rd));

        // Randomized transactions against the model
        for (int n = 0; n < 36; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == K_R)                      id = 8'h43;
            else if ($urandom_range(0, 5) == 0)   id = bad_ids[$urandom_range(0, 3)];
            else                                  id = 8'h42;
            sub  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            data = 8'($urandom_range(0, 255));
            apply_stimulus(kind, id, sub, data, $sformatf("rnd%0d", n), rd);
            model_txn(kind, id, sub, data, exp_vld, exp_rd);
            check_commit(exp_vld, sub, data, $sformatf("rnd%0d", n));
            if (kind == K_R) check_output($sformatf("rnd%0d read data", n), 32'(rd), 32'(exp_rd));
        end

        // Reset pulsed while the slave is driving a read bit
        apply_stimulus(K_W3, 8'h42, 8'h00, 8'h9E, "rst w", rd);
        model_txn(K_W3, 8'h42, 8'h00, 8'h9E, exp_vld, exp_rd);
        check_commit(1'b1, 8'h00, 8'h9E, "rst w");
        sccb_start();
        write_byte(8'h43, ACK_EN, "rst id");
        for (int i = 0; i < 4; i++) send_bit(1'b1, s, drv);
        master_d = 1'b1;
        wait_q();
        master_c = 1'b1;
        wait_q();
        check_output("rdat oe before reset", 32'(sif.sio_d_oe_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("outputs right after async reset",
                     32'({sif.sio_d_o, sif.sio_d_oe_o, sif.wr_vld_o, sif.wr_addr_o, sif.wr_data_o, sif.busy_o}),
                     32'd0);
        master_c = 1'b1;
        master_d = 1'b1;
        repeat (5) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        model_reset();
        check_commit(1'b0, 8'h00, 8'h00, "rst");
        apply_stimulus(K_R, 8'h43, 8'h00, 8'h00, "rst rd", rd);
        model_txn(K_R, 8'h43, 8'h00, 8'h00, exp_vld, exp_rd);
        check_output("read after reset", 32'(rd), 32'(exp_rd));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
